nco_phase_detector: RTL and testbench

- Receive end of the NCO sample interface: takes a signed 5-bit sine/cosine (I/Q) pair and recovers its phase in the NCO's 8-bit phase units, where 256 counts = 1 turn.
- Uses an iterative CORDIC in vectoring mode.
- Differences successive phases to estimate the phase increment, i.e. frequency, of the incoming tone.
- Used for loopback self-test of the NCO and as the phase-error front end of a future carrier-tracking loop.

---
 rtl/nco_phase_detector.sv | 215 +++++++++++++++++++++
 tb/tb_nco_phase_detector.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_phase_detector.sv
// nco_phase_detector: recovers the phase of a 5-bit I/Q sample pair with a vectoring-mode CORDIC.
// Frequency estimate (successive phase difference) is built only when NCO_PHASE_DETECTOR_FREQ_EST_EN is defined.
`timescale 1ns/1ps

module nco_phase_detector #(
  parameter int ITERATIONS = 8,
  parameter int Z_W        = 12
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic       sample_valid,
  input  logic [4:0] sine_bits,
  input  logic [4:0] cosine_bits,
  output logic       ready,
  output logic [7:0] phase,
  output logic       phase_valid,
  output logic [7:0] freq_word,
  output logic       freq_valid,
  output logic       overrun
);

  // state   | meaning
  // IDLE    | ready; waiting for a sample
  // PREROT  | fold the left half-plane onto the right, seed z
  // ITER    | ITERATIONS CORDIC micro-rotations driving y to zero
  // DONE    | round z into phase, update frequency estimate

  localparam int XY_W  = 7 + ITERATIONS;
  localparam int CNT_W = $clog2(ITERATIONS + 1);
  localparam logic [Z_W-1:0] HALF_TURN = {1'b1, {(Z_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_PREROT, S_ITER, S_DONE} state_e;

  state_e state_q, state_d;

  logic signed [XY_W-1:0] x_q, x_d, y_q, y_d;
  logic signed [XY_W-1:0] x_in, y_in, x_sh, y_sh;
  logic        [Z_W-1:0]  z_q, z_d, atan_i;
  logic        [CNT_W-1:0] iter_q, iter_d;
  logic                   zero_q, zero_d;
  logic                   iter_last;
  logic                   load_xy, do_prerot, do_iter, do_done;
  logic        [7:0]      phase_new;
  logic        [7:0]      phase_q;
  logic                   phase_valid_q;
  logic                   overrun_q;

  function automatic logic [Z_W-1:0] atan_lut(input int idx);
    case (idx)
      0:       atan_lut = Z_W'(512);
      1:       atan_lut = Z_W'(302);
      2:       atan_lut = Z_W'(160);
      3:       atan_lut = Z_W'(81);
      4:       atan_lut = Z_W'(41);
      5:       atan_lut = Z_W'(20);
      6:       atan_lut = Z_W'(10);
      7:       atan_lut = Z_W'(5);
      8:       atan_lut = Z_W'(3);
      9:       atan_lut = Z_W'(1);
      default: atan_lut = '0;
    endcase
  endfunction

  assign iter_last = (iter_q == CNT_W'(ITERATIONS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (sample_valid) state_d = S_PREROT;
      S_PREROT: state_d = S_ITER;
      S_ITER:   if (iter_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    load_xy   = 1'b0;
    do_prerot = 1'b0;
    do_iter   = 1'b0;
    do_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready   = 1'b1;
        load_xy = sample_valid;
      end
      S_PREROT: do_prerot = 1'b1;
      S_ITER:   do_iter   = 1'b1;
      S_DONE:   do_done   = 1'b1;
      default:  ready     = 1'b0;
    endcase
  end

  // Guard bits keep the micro-rotation shifts from discarding resolution.
  assign x_in   = {{(XY_W-5){cosine_bits[4]}}, cosine_bits} <<< ITERATIONS;
  assign y_in   = {{(XY_W-5){sine_bits[4]}},   sine_bits}   <<< ITERATIONS;
  assign x_sh   = x_q >>> iter_q;
  assign y_sh   = y_q >>> iter_q;
  assign atan_i = atan_lut(int'(iter_q));

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    iter_d = iter_q;
    zero_d = zero_q;
    if (load_xy) begin
      x_d    = x_in;
      y_d    = y_in;
      z_d    = '0;
      iter_d = '0;
      zero_d = (sine_bits == 5'd0) && (cosine_bits == 5'd0);
    end else if (do_prerot) begin
      if (x_q[XY_W-1]) begin
        x_d = -x_q;
        y_d = -y_q;
        z_d = HALF_TURN;
      end else begin
        z_d = '0;
      end
    end else if (do_iter) begin
      if (!y_q[XY_W-1]) begin
        x_d = x_q + y_sh;
        y_d = y_q - x_sh;
        z_d = z_q + atan_i;
      end else begin
        x_d = x_q - y_sh;
        y_d = y_q + x_sh;
        z_d = z_q - atan_i;
      end
      iter_d = iter_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      iter_q <= '0;
      zero_q <= 1'b0;
    end else if (clk_en) begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      iter_q <= iter_d;
      zero_q <= zero_d;
    end
  end

  // (z + 8) >> 4 without a wide adder: top byte plus the rounding bit. A zero vector has no angle.
  assign phase_new = zero_q ? 8'd0 : (z_q[Z_W-1 -: 8] + 8'(z_q[Z_W-9]));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else if (clk_en) begin
      phase_valid_q <= do_done;
      if (do_done) begin
        phase_q <= phase_new;
      end
      if (sample_valid && !ready) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign overrun     = overrun_q;

`ifdef NCO_PHASE_DETECTOR_FREQ_EST_EN
  logic [7:0] prev_q;
  logic       have_prev_q;
  logic [7:0] freq_word_q;
  logic       freq_valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q       <= '0;
      have_prev_q  <= 1'b0;
      freq_word_q  <= '0;
      freq_valid_q <= 1'b0;
    end else if (clk_en) begin
      freq_valid_q <= do_done && have_prev_q;
      if (do_done) begin
        if (have_prev_q) begin
          freq_word_q <= phase_new - prev_q;
        end
        prev_q      <= phase_new;
        have_prev_q <= 1'b1;
      end
    end
  end

  assign freq_word  = freq_word_q;
  assign freq_valid = freq_valid_q;
`else
  assign freq_word  = 8'd0;
  assign freq_valid = 1'b0;
`endif

endmodule

// File: tb/tb_nco_phase_detector.sv
// Directed bench for nco_phase_detector: table of I/Q vectors plus hand-written overrun,
// clk_en gating, mid-operation reset and NCO loopback sequences.
`timescale 1ns/1ps

module tb_nco_phase_detector;

  logic       clock;
  logic       reset_n;
  logic       clk_en;
  logic       sample_valid;
  logic [4:0] sine_bits;
  logic [4:0] cosine_bits;
  logic       ready;
  logic [7:0] phase;
  logic       phase_valid;
  logic [7:0] freq_word;
  logic       freq_valid;
  logic       overrun;

`ifdef NCO_PHASE_DETECTOR_FREQ_EST_EN
  localparam int FE = 1;
`else
  localparam int FE = 0;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string name;
    int    y;
    int    x;
    int    exp_ph;
    int    tol;
  } vec_t;

  vec_t vecs[9];

  nco_phase_detector dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clk_en       (clk_en),
    .sample_valid (sample_valid),
    .sine_bits    (sine_bits),
    .cosine_bits  (cosine_bits),
    .ready        (ready),
    .phase        (phase),
    .phase_valid  (phase_valid),
    .freq_word    (freq_word),
    .freq_valid   (freq_valid),
    .overrun      (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Circular compare in 256-count phase units.
  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    int d;
    checks++;
    d = (((act - exp) % 256) + 256) % 256;
    if (d >= 128) d -= 256;
    if (d > tol || d < -tol) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    clk_en       = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_result(input bit toggle, output int lat, output int clocks);
    lat    = 0;
    clocks = 0;
    while (!phase_valid && clocks < 64) begin
      clk_en = toggle ? ~clk_en : 1'b1;
      step();
      clocks++;
      if (clk_en) lat++;
    end
    clk_en = 1'b1;
    if (!phase_valid) begin
      checks++;
      failures++;
      $display("FAIL result_timeout: phase_valid=0 after %0d clocks, required 1", clocks);
    end
  endtask

  task automatic apply(input int y, input int x, input bit toggle,
                       output int ph, output int fv, output int fw,
                       output int lat, output int clocks);
    sine_bits    = 5'(y);
    cosine_bits  = 5'(x);
    sample_valid = 1'b1;
    clk_en       = 1'b1;
    step();
    sample_valid = 1'b0;
    wait_result(toggle, lat, clocks);
    ph = int'(phase);
    fv = int'(freq_valid);
    fw = int'(freq_word);
  endtask

  function automatic int model_phase(input int y, input int x);
    real a;
    int  r;
    a = $atan2(real'(y), real'(x)) * 128.0 / 3.14159265358979;
    if (a < 0.0) a = a + 256.0;
    r = int'(a);
    return ((r % 256) + 256) % 256;
  endfunction

  initial begin
    int ph, fv, fw, lat, clks;
    int exp_fv, prev_exp, prev_tol, e, ys, xs;
    real ang;

    // (-16,15) sits at 222.7 counts, so the rounded ideal is 223.
    vecs[0] = '{"axis0",   0,  15,   0, 0};
    vecs[1] = '{"axis64",  15,  0,  64, 0};
    vecs[2] = '{"axis128", 0, -15, 128, 0};
    vecs[3] = '{"axis192", -15, 0, 192, 0};
    vecs[4] = '{"diag32",  10,  10,  32, 1};
    vecs[5] = '{"diag96",  10, -10,  96, 1};
    vecs[6] = '{"diag160", -10, -10, 160, 1};
    vecs[7] = '{"diag223", -16, 15, 223, 1};
    vecs[8] = '{"zero",    0,   0,   0, 0};

    sine_bits   = '0;
    cosine_bits = '0;
    do_reset();

    check_eq("reset_ready",       int'(ready), 1);
    check_eq("reset_phase",       int'(phase), 0);
    check_eq("reset_phase_valid", int'(phase_valid), 0);
    check_eq("reset_freq_word",   int'(freq_word), 0);
    check_eq("reset_freq_valid",  int'(freq_valid), 0);
    check_eq("reset_overrun",     int'(overrun), 0);

    prev_exp = 0;
    prev_tol = 0;
    for (int k = 0; k < 9; k++) begin
      apply(vecs[k].y, vecs[k].x, 1'b0, ph, fv, fw, lat, clks);
      check_tol({vecs[k].name, "_phase"}, ph, vecs[k].exp_ph, vecs[k].tol);
      check_eq({vecs[k].name, "_latency"}, lat, 10);
      exp_fv = (FE != 0 && k > 0) ? 1 : 0;
      check_eq({vecs[k].name, "_freq_valid"}, fv, exp_fv);
      if (exp_fv != 0)
        check_tol({vecs[k].name, "_freq_word"}, fw, vecs[k].exp_ph - prev_exp, vecs[k].tol + prev_tol);
      else
        check_eq({vecs[k].name, "_freq_word"}, fw, 0);
      prev_exp = vecs[k].exp_ph;
      prev_tol = vecs[k].tol;
    end

    // Overrun: a second sample three cycles into a conversion is dropped.
    sine_bits    = 5'(15);
    cosine_bits  = 5'(0);
    sample_valid = 1'b1;
    clk_en       = 1'b1;
    step();
    sample_valid = 1'b0;
    repeat (2) step();
    sine_bits    = 5'(0);
    cosine_bits  = 5'(-15);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check_eq("overrun_set", int'(overrun), 1);
    check_eq("overrun_busy_ready", int'(ready), 0);
    wait_result(1'b0, lat, clks);
    check_eq("overrun_remaining_latency", lat, 7);
    check_eq("overrun_first_phase", int'(phase), 64);
    repeat (3) step();
    check_eq("overrun_sticky", int'(overrun), 1);
    check_eq("overrun_idle_ready", int'(ready), 1);

    // clk_en toggling every cycle doubles wall-clock latency only.
    apply(10, 10, 1'b1, ph, fv, fw, lat, clks);
    check_tol("gated_diag32_phase", ph, 32, 1);
    check_eq("gated_latency_enabled", lat, 10);
    check_eq("gated_latency_clocks", clks, 20);
    clk_en = 1'b0;
    step();
    check_eq("pulse_held_while_disabled", int'(phase_valid), 1);
    clk_en = 1'b1;
    step();
    check_eq("pulse_cleared_next_enabled", int'(phase_valid), 0);
    apply(-15, 0, 1'b1, ph, fv, fw, lat, clks);
    check_eq("gated_axis192_phase", ph, 192);
    check_eq("gated_axis192_clocks", clks, 20);

    // Reset in the middle of ITER.
    sine_bits    = 5'(0);
    cosine_bits  = 5'(15);
    sample_valid = 1'b1;
    clk_en       = 1'b1;
    step();
    sample_valid = 1'b0;
    repeat (4) step();
    check_eq("midreset_busy", int'(ready), 0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midreset_ready",       int'(ready), 1);
    check_eq("midreset_phase",       int'(phase), 0);
    check_eq("midreset_phase_valid", int'(phase_valid), 0);
    check_eq("midreset_freq_word",   int'(freq_word), 0);
    check_eq("midreset_freq_valid",  int'(freq_valid), 0);
    check_eq("midreset_overrun",     int'(overrun), 0);
    step();
    reset_n = 1'b1;
    step();
    apply(15, 0, 1'b0, ph, fv, fw, lat, clks);
    check_eq("post_reset_first_phase", ph, 64);
    check_eq("post_reset_first_freq_valid", fv, 0);
    apply(0, -15, 1'b0, ph, fv, fw, lat, clks);
    check_eq("post_reset_second_phase", ph, 128);
    check_eq("post_reset_second_freq_valid", fv, FE);
    exp_fv = FE;
    if (exp_fv != 0)
      check_eq("post_reset_second_freq_word", fw, 64);
    else
      check_eq("post_reset_second_freq_word", fw, 0);

    // Loopback from an NCO model stepping 5 counts per sample, crossing 255->0.
    do_reset();
    prev_exp = 0;
    for (int k = 0; k < 8; k++) begin
      ang = 2.0 * 3.14159265358979 * real'((240 + 5 * k) % 256) / 256.0;
      ys  = int'(15.0 * $sin(ang));
      xs  = int'(15.0 * $cos(ang));
      e   = model_phase(ys, xs);
      apply(ys, xs, 1'b0, ph, fv, fw, lat, clks);
      check_tol($sformatf("loop%0d_phase", k), ph, e, 1);
      check_eq($sformatf("loop%0d_latency", k), lat, 10);
      exp_fv = (FE != 0 && k > 0) ? 1 : 0;
      check_eq($sformatf("loop%0d_freq_valid", k), fv, exp_fv);
      if (exp_fv != 0)
        check_tol($sformatf("loop%0d_freq_word", k), fw, e - prev_exp, 2);
      else
        check_eq($sformatf("loop%0d_freq_word", k), fw, 0);
      prev_exp = e;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
